uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial receiver, 8N1, counterpart of the uart transmitter on the CPU's UART port.
//   Samples the RX pin and buffers received bytes in a small show-ahead FIFO.
//   The data_mem load path reads the head byte and status flags at the UART address.
//   A load pulse pops the head byte.
// PARAMETERS
//   CLK_HZ      100_000_000  sys_clk_i frequency in Hz
//   BAUD        115200       line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4)
//   FIFO_DEPTH  4            receive buffer entries; power of two, 2..16
// PORTS
//   sys_clk_i     in   1  system clock, rising edge
//   sys_rstn_i    in   1  asynchronous active-low reset
//   uart_rx       in   1  serial input, asynchronous to sys_clk_i, idles high
//   uart_rd_i     in   1  one-cycle pop request (CPU load of the UART data address)
//   uart_clr_i    in   1  one-cycle clear of the sticky error flags
//   uart_dat_o    out  8  FIFO head byte; 8'h00 when empty
//   uart_valid_o  out  1  FIFO not empty
//   uart_full_o   out  1  FIFO holds FIFO_DEPTH bytes
//   uart_ovf_o    out  1  sticky: a byte was dropped because the FIFO was full
//   uart_ferr_o   out  1  sticky: a stop bit was sampled low
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - FSM goes to IDLE; bit/clock counters = 0; FIFO empty.
//     - All outputs 0; synchronizer flops = 1.
//     - Reset mid-frame discards the partial byte.
//   Input: uart_rx passes through a 2-flop synchronizer. A falling edge is a synchronized 1->0 transition.
//   FSM:
//     - IDLE: on a falling edge, clk_cnt<=0 and go to START.
//     - START: at clk_cnt == CLKS_PER_BIT/2-1, sample the line.
//         - Line = 1: glitch; go to IDLE, no flag.
//         - Line = 0: clk_cnt<=0, bit_cnt<=0, go to DATA.
//     - DATA: each time clk_cnt == CLKS_PER_BIT-1, sample into shift[bit_cnt] (LSB first) and clk_cnt<=0.
//         After bit_cnt == 7 is sampled, go to STOP.
//     - STOP: at clk_cnt == CLKS_PER_BIT-1, sample the line.
//         - Line = 1: push the byte.
//         - Line = 0: drop the byte and set ferr.
//         - Either way go to IDLE. A low line in IDLE does not restart; only a new falling edge does.
//   Latency: the pushed byte appears on uart_dat_o, with uart_valid_o=1, in the cycle after the stop sample.
//   FIFO:
//     - Show-ahead: uart_dat_o always reflects the head entry, combinationally from the registered array and pointers.
//     - Pointers wrap modulo FIFO_DEPTH.
//     - uart_rd_i while empty is ignored: no pointer change, no flag.
//     - Push while full without a pop: drop the new byte, set ovf. FIFO contents are unchanged.
//     - Push and pop in the same cycle, including when full: both take effect and the count is unchanged.
//       Push and pop on an empty FIFO: only the push takes effect.
//   Flags:
//     - ovf and ferr stay set until uart_clr_i or reset.
//     - If uart_clr_i coincides with a new error event, the flag ends set (set wins).
//   Width rules: clk_cnt is $clog2(CLKS_PER_BIT) bits; count is $clog2(FIFO_DEPTH)+1 bits.
// TESTING (CLK_HZ=1_000_000, BAUD=100_000 -> 10 clk/bit, FIFO_DEPTH=4)
//   1. Send 0x55, valid stop bit.
//      -> uart_valid_o=1 and uart_dat_o=0x55, 1 cycle after the stop sample (~95 clk after the start edge).
//      -> Pulse uart_rd_i: valid=0, dat=0x00.
//   2. Low pulse of 3 clk on an idle line.
//      -> No byte received, valid=0, ferr=0; a following 0xA3 frame is received correctly.
//   3. Send 0x81 with stop bit held low.
//      -> valid stays 0, ferr=1.
//      -> Pulse uart_clr_i: ferr=0.
//      -> A next frame 0x7E (sent after the line returns high) is received correctly.
//   4. Send 0x01,0x02,0x03,0x04,0x05 with no reads.
//      -> full=1 after 0x04, ovf=1 after 0x05.
//      -> Four pops return 0x01..0x04, then valid=0.
//   5. FIFO full; assert uart_rd_i in the same cycle as the push of 0x10.
//      -> ovf stays 0, full stays 1, 0x10 is read last.
//   6. Assert sys_rstn_i low mid-DATA of 0xC3, release, send 0x3C.
//      -> Only 0x3C is received; all flags 0.

Source files
------------

// File: rtl/uart_rx_if.sv
// Bus between the UART receiver and the CPU load path: serial line in,
// pop/clear strobes in, head byte and status flags out.
interface uart_rx_if;
    logic       uart_rx;
    logic       uart_rd_i;
    logic       uart_clr_i;
    logic [7:0] uart_dat_o;
    logic       uart_valid_o;
    logic       uart_full_o;
    logic       uart_ovf_o;
    logic       uart_ferr_o;

    modport slave (
        input  uart_rx, uart_rd_i, uart_clr_i,
        output uart_dat_o, uart_valid_o, uart_full_o, uart_ovf_o, uart_ferr_o
    );

    modport master (
        output uart_rx, uart_rd_i, uart_clr_i,
        input  uart_dat_o, uart_valid_o, uart_full_o, uart_ovf_o, uart_ferr_o
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver feeding a small show-ahead FIFO read by CPU loads.
// Sticky overflow and framing-error flags are cleared by a clear strobe.
module uart_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk_i,
    input  logic       sys_rstn_i,
    uart_rx_if.slave   bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNTF_W       = PTR_W + 1;

    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNTF_W-1:0] DEPTH_C  = CNTF_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic [1:0]        sync_q;
    logic              rx_prev;
    logic              rx_s;
    logic              fall;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNTF_W-1:0] count;
    logic              ovf_q;
    logic              ferr_q;

    logic data_sample;
    logic stop_sample;
    logic push;
    logic frame_err;
    logic empty;
    logic full;
    logic pop;
    logic wr_ok;

    // Two-flop synchronizer; rx_prev gives the previous synchronized level for edge detection.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], bus.uart_rx};
            rx_prev <= sync_q[1];
        end
    end

    assign rx_s = sync_q[1];
    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        clk_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (clk_cnt == BIT_HALF) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            clk_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) state <= STOP;
                        else                 bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign data_sample = (state == DATA) && (clk_cnt == BIT_LAST);
    assign stop_sample = (state == STOP) && (clk_cnt == BIT_LAST);
    assign push        = stop_sample & rx_s;
    assign frame_err   = stop_sample & ~rx_s;

    always_ff @(posedge sys_clk_i) begin
        if (data_sample) shift[bit_cnt] <= rx_s;
    end

    // FIFO: a pop frees the slot the push lands in, so push+pop while full is legal.
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign pop   = bus.uart_rd_i & ~empty;
    assign wr_ok = push & (~full | pop);

    always_ff @(posedge sys_clk_i) begin
        if (wr_ok) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !pop)      count <= count + 1'b1;
            else if (!wr_ok && pop) count <= count - 1'b1;

            if (push && full && !pop) ovf_q <= 1'b1;
            else if (bus.uart_clr_i)  ovf_q <= 1'b0;

            if (frame_err)            ferr_q <= 1'b1;
            else if (bus.uart_clr_i)  ferr_q <= 1'b0;
        end
    end

    assign bus.uart_dat_o   = empty ? 8'h00 : mem[rd_ptr];
    assign bus.uart_valid_o = ~empty;
    assign bus.uart_full_o  = full;
    assign bus.uart_ovf_o   = ovf_q;
    assign bus.uart_ferr_o  = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit with a 4-entry FIFO:
// a vector table of single frames plus hand-written multi-frame sequences.
`timescale 1ns/1ps
module tb_uart_rx;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if bus();

    uart_rx #(
        .CLK_HZ    (1_000_000),
        .BAUD      (100_000),
        .FIFO_DEPTH(4)
    ) dut (
        .sys_clk_i (clk),
        .sys_rstn_i(rstn),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 0;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_dat;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        bus.uart_rx = 1'b0;
        hold(10);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            hold(10);
        end
        bus.uart_rx = stop;
        hold(10);
        bus.uart_rx = 1'b1;
        hold(4);
    endtask

    task automatic pulse_rd();
        bus.uart_rd_i = 1'b1;
        hold(1);
        bus.uart_rd_i = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.uart_clr_i = 1'b1;
        hold(1);
        bus.uart_clr_i = 1'b0;
    endtask

    initial begin
        hold(50000);
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{"vec_a3",   8'hA3, 1'b1, 1'b1, 8'hA3, 1'b0};
        vecs[1] = '{"vec_00",   8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{"vec_ff",   8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{"vec_81_fe",8'h81, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{"vec_7e",   8'h7E, 1'b1, 1'b1, 8'h7E, 1'b0};
        vecs[5] = '{"vec_80",   8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
        vecs[6] = '{"vec_5a_fe",8'h5A, 1'b0, 1'b0, 8'h00, 1'b1};

        bus.uart_rx    = 1'b1;
        bus.uart_rd_i  = 1'b0;
        bus.uart_clr_i = 1'b0;
        hold(3);
        chk("rst_valid", bus.uart_valid_o, 0);
        chk("rst_dat",   bus.uart_dat_o,   0);
        chk("rst_full",  bus.uart_full_o,  0);
        chk("rst_ovf",   bus.uart_ovf_o,   0);
        chk("rst_ferr",  bus.uart_ferr_o,  0);
        rstn = 1'b1;
        hold(3);

        // Frame 0x55 with latency measured from the start-bit edge.
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(posedge clk);
                #1;
                lat = 0;
                while (!bus.uart_valid_o && lat < 200) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        chk("lat_window", int'(lat >= 92 && lat <= 100), 1);
        chk("t1_dat",   bus.uart_dat_o,   8'h55);
        chk("t1_valid", bus.uart_valid_o, 1);
        pulse_rd();
        chk("t1_pop_valid", bus.uart_valid_o, 0);
        chk("t1_pop_dat",   bus.uart_dat_o,   0);

        pulse_rd();
        chk("rd_empty_valid", bus.uart_valid_o, 0);
        chk("rd_empty_full",  bus.uart_full_o,  0);

        // Short low glitch must not start a frame.
        bus.uart_rx = 1'b0;
        hold(3);
        bus.uart_rx = 1'b1;
        hold(30);
        chk("glitch_valid", bus.uart_valid_o, 0);
        chk("glitch_ferr",  bus.uart_ferr_o,  0);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            chk({vecs[i].name, "_valid"}, bus.uart_valid_o, vecs[i].exp_valid);
            chk({vecs[i].name, "_dat"},   bus.uart_dat_o,   vecs[i].exp_dat);
            chk({vecs[i].name, "_ferr"},  bus.uart_ferr_o,  vecs[i].exp_ferr);
            chk({vecs[i].name, "_ovf"},   bus.uart_ovf_o,   0);
            if (vecs[i].exp_valid) begin
                pulse_rd();
                chk({vecs[i].name, "_popped"}, bus.uart_valid_o, 0);
            end
            if (vecs[i].exp_ferr) begin
                pulse_clr();
                chk({vecs[i].name, "_clr"}, bus.uart_ferr_o, 0);
            end
        end

        // Fill the FIFO, then overflow it.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        chk("fill_full",  bus.uart_full_o, 1);
        chk("fill_ovf",   bus.uart_ovf_o,  0);
        chk("fill_head",  bus.uart_dat_o,  8'h01);
        send_frame(8'h05, 1'b1);
        chk("ovf_set",    bus.uart_ovf_o,  1);
        chk("ovf_full",   bus.uart_full_o, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_pop%0d", i), bus.uart_dat_o, i);
            pulse_rd();
        end
        chk("ovf_drained", bus.uart_valid_o, 0);
        pulse_clr();
        chk("ovf_clr", bus.uart_ovf_o, 0);

        // Pop in the very cycle of the push into a full FIFO.
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
        chk("sim_full_pre", bus.uart_full_o, 1);
        fork
            send_frame(8'h10, 1'b1);
            begin
                @(posedge clk);
                #1;
                hold(lat - 1);
                bus.uart_rd_i = 1'b1;
                hold(1);
                bus.uart_rd_i = 1'b0;
            end
        join
        chk("sim_ovf",  bus.uart_ovf_o,  0);
        chk("sim_full", bus.uart_full_o, 1);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 3) ? 8'h12 + 8'(i) : 8'h10;
            chk($sformatf("sim_pop%0d", i), bus.uart_dat_o, exp_b);
            pulse_rd();
        end
        chk("sim_empty", bus.uart_valid_o, 0);

        // Clear strobe coinciding with a framing error: set wins.
        fork
            send_frame(8'h81, 1'b0);
            begin
                @(posedge clk);
                #1;
                hold(lat - 1);
                bus.uart_clr_i = 1'b1;
                hold(1);
                bus.uart_clr_i = 1'b0;
            end
        join
        chk("clr_vs_ferr", bus.uart_ferr_o, 1);
        pulse_clr();
        chk("clr_after", bus.uart_ferr_o, 0);

        // Reset in the middle of a frame with a byte buffered and ferr set.
        send_frame(8'h44, 1'b1);
        send_frame(8'h81, 1'b0);
        chk("pre_rst_valid", bus.uart_valid_o, 1);
        chk("pre_rst_ferr",  bus.uart_ferr_o,  1);
        fork
            send_frame(8'hC3, 1'b1);
            begin
                @(posedge clk);
                #1;
                hold(40);
                rstn = 1'b0;
            end
        join
        chk("mid_rst_valid", bus.uart_valid_o, 0);
        rstn = 1'b1;
        hold(3);
        send_frame(8'h3C, 1'b1);
        chk("post_rst_valid", bus.uart_valid_o, 1);
        chk("post_rst_dat",   bus.uart_dat_o,   8'h3C);
        chk("post_rst_ferr",  bus.uart_ferr_o,  0);
        chk("post_rst_ovf",   bus.uart_ovf_o,   0);
        chk("post_rst_full",  bus.uart_full_o,  0);
        pulse_rd();
        chk("post_rst_empty", bus.uart_valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
